// File: rtl/lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu : multi-cycle RV32I load/store unit driving a valid/ready data bus
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sign_ext,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_stall,
  output logic [31:0]           o_rdata,
  output logic                  o_rvalid,
  output logic                  o_misaligned,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [1:0]            off_q, off_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  misaligned_q, misaligned_d;

  logic                  w_misaligned;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load;

  assign w_misaligned = (i_size == 2'b11)
                      | ((i_size == 2'b01) & i_addr[0])
                      | ((i_size == 2'b10) & (|i_addr[1:0]));

  // Store lane steering from the live request; it is captured on IDLE->REQ.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    case (i_size)
      2'b00: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
      end
    endcase
  end

  assign w_shifted = i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (size_q)
      2'b00:   w_load = {{24{sext_q & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{sext_q & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sext_d       = sext_q;
    off_d        = off_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          size_d = i_size;
          sext_d = i_sign_ext;
          off_d  = i_addr[1:0];
          if (w_misaligned) begin
            misaligned_d = 1'b1;
            state_d      = DONE;
          end else begin
            mem_valid_d = 1'b1;
            mem_we_d    = i_we;
            mem_be_d    = w_be;
            mem_addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = w_wdata;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = mem_we_q ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (i_mem_rvalid) begin
          rdata_d  = w_load;
          rvalid_d = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      off_q        <= 2'b00;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      rdata_q      <= 32'd0;
      rvalid_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      off_q        <= off_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_stall      = i_req & (state_q != DONE);
  assign o_rdata      = rdata_q;
  assign o_rvalid     = rvalid_q;
  assign o_misaligned = misaligned_q;
  assign o_mem_valid  = mem_valid_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_be     = mem_be_q;
  assign o_mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu : vector table, directed corner sequences and random ops vs. model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        i_rst_n, i_req, i_we, i_sign_ext, i_mem_ready, i_mem_rvalid;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic        o_stall, o_rvalid, o_misaligned, o_mem_valid, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  lsu #(.ADDR_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
    .i_size(i_size), .i_sign_ext(i_sign_ext), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .o_misaligned(o_misaligned), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memword;
    int          rw;
    int          rd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        b2b;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: lanes and extraction derived from byte counts and offsets.
  function automatic void model(input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] memword,
                                input logic sext, output logic mis,
                                output logic [31:0] e_addr, output logic [3:0] be,
                                output logic [31:0] ew, output logic [31:0] er);
    int          n;
    int          off;
    logic [31:0] mask;
    logic [31:0] v;
    n      = 1 << size;
    off    = int'(addr % 4);
    mis    = (size == 2'd3) || ((off % n) != 0);
    e_addr = addr - 32'(off);
    be     = 4'b0;
    ew     = 32'd0;
    er     = 32'd0;
    if (!mis) begin
      be = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) ew[8*i +: 8] = wdata[8*(i % n) +: 8];
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v    = (memword >> (8 * off)) & mask;
      if (sext && v[8*n-1]) v = v | ~mask;
      er   = v;
    end
  endfunction

  task automatic idle_cycle();
    step();
    i_req        = 1'b0;
    i_mem_ready  = 1'($urandom);
    i_mem_rvalid = 1'($urandom);
    i_mem_rdata  = $urandom;
    #1;
    check("idle_stall", o_stall, 0);
    check("idle_valid", o_mem_valid, 0);
    check("idle_rvalid", o_rvalid, 0);
    check("idle_mis", o_misaligned, 0);
    check("idle_rdata", o_rdata, last_rdata);
  endtask

  // Drives one op starting in an IDLE cycle and ends in its DONE cycle.
  task automatic run_op(input vec_t v);
    step();
    i_req = 1'b1; i_we = v.we; i_size = v.size; i_sign_ext = v.sext;
    i_addr = v.addr; i_wdata = v.wdata; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    #1;
    check("c0_stall", o_stall, 1);
    check("c0_valid", o_mem_valid, 0);
    if (v.e_mis) begin
      step();
      #1;
      check("mis_pulse", o_misaligned, 1);
      check("mis_rvalid", o_rvalid, 0);
      check("mis_stall", o_stall, 0);
      check("mis_valid", o_mem_valid, 0);
      check("mis_rdata_kept", o_rdata, last_rdata);
    end else begin
      for (int k = 0; k <= v.rw; k++) begin
        step();
        i_mem_ready = (k == v.rw);
        #1;
        check("req_valid", o_mem_valid, 1);
        check("req_addr", o_mem_addr, v.e_addr);
        check("req_we", o_mem_we, v.we);
        check("req_stall", o_stall, 1);
        if (v.we) begin
          check("req_be", o_mem_be, v.e_be);
          check("req_wdata", o_mem_wdata, v.e_wdata);
        end
      end
      if (!v.we) begin
        for (int k = 0; k <= v.rd; k++) begin
          step();
          i_mem_ready  = 1'b0;
          i_mem_rvalid = (k == v.rd);
          i_mem_rdata  = (k == v.rd) ? v.memword : $urandom;
          #1;
          check("wait_stall", o_stall, 1);
          check("wait_valid", o_mem_valid, 0);
          check("wait_rvalid", o_rvalid, 0);
        end
      end
      step();
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;
      #1;
      check("done_stall", o_stall, 0);
      check("done_valid", o_mem_valid, 0);
      check("done_mis", o_misaligned, 0);
      check("done_rvalid", o_rvalid, !v.we);
      if (!v.we) begin
        check("done_rdata", o_rdata, v.e_rdata);
        last_rdata = v.e_rdata;
      end
    end
  endtask

  initial begin
    vec_t rv;
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_sign_ext = 1'b0;
    i_addr = 32'd0; i_wdata = 32'd0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = 32'd0; last_rdata = 32'd0;

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, 32'h2000, 4'b0, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, 32'h2000, 4'b0, 32'h0, 32'h0000_8001, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 32'h0040, 32'h1234_5678, 32'h0, 3, 0, 32'h0040, 4'b1111, 32'h1234_5678, 32'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h5001, 32'h0, 32'h0000_FF00, 0, 0, 32'h5000, 4'b0, 32'h0, 32'h0000_00FF, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h5002, 32'h0000_003C, 32'h0, 0, 0, 32'h5000, 4'b0100, 32'h3C3C_3C3C, 32'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h6002, 32'hABCD_BEEF, 32'h0, 1, 0, 32'h6000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'd3, 1'b1, 32'h7000, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h6001, 32'h1234, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 32'h8003, 32'h0, 32'h8000_0000, 0, 2, 32'h8000, 4'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'd1, 1'b1, 32'h9000, 32'h0, 32'h0000_7FFF, 2, 1, 32'h9000, 4'b0, 32'h0, 32'h0000_7FFF, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    check("rst_stall", o_stall, 0);
    check("rst_valid", o_mem_valid, 0);
    check("rst_we", o_mem_we, 0);
    check("rst_be", o_mem_be, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_wdata", o_mem_wdata, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_mis", o_misaligned, 0);

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i]);
      if (!tbl[i].b2b) idle_cycle();
    end

    // Reset while waiting for read data; the late response must be dropped.
    step();
    i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_sign_ext = 1'b0; i_addr = 32'hA000;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    step();
    i_mem_ready = 1'b1;
    #1;
    check("rstw_req_valid", o_mem_valid, 1);
    step();
    i_mem_ready = 1'b0;
    i_rst_n     = 1'b0;
    #1;
    check("rstw_wait_stall", o_stall, 1);
    step();
    i_rst_n = 1'b1; i_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rstw_stall", o_stall, 0);
    check("rstw_rvalid", o_rvalid, 0);
    check("rstw_rdata", o_rdata, 0);
    check("rstw_valid", o_mem_valid, 0);
    step();
    i_mem_rvalid = 1'b0;
    #1;
    check("rstw_rvalid2", o_rvalid, 0);
    check("rstw_rdata2", o_rdata, 0);
    last_rdata = 32'd0;

    for (int i = 0; i < 80; i++) begin
      rv.we      = 1'($urandom);
      rv.size    = 2'($urandom);
      rv.sext    = 1'($urandom);
      rv.addr    = $urandom;
      rv.wdata   = $urandom;
      rv.memword = $urandom;
      rv.rw      = int'($urandom_range(0, 2));
      rv.rd      = int'($urandom_range(0, 2));
      rv.b2b     = 1'($urandom);
      model(rv.size, rv.addr, rv.wdata, rv.memword, rv.sext,
            rv.e_mis, rv.e_addr, rv.e_be, rv.e_wdata, rv.e_rdata);
      run_op(rv);
      if (!rv.b2b) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
